// File: rtl/dec_fault_monitor_if.sv
// Sample/result bundle between a 4-to-16 decoder test harness and dec_fault_monitor.
// Optional FIRST_FAULT_CAPTURE_EN adds first_addr/first_vld.
interface dec_fault_monitor_if #(
    parameter int unsigned N_CODES = 16,
    parameter int unsigned CNT_W   = 5
) ();
    localparam int unsigned A_W = $clog2(N_CODES);

    logic               start;
    logic               valid;
    logic [A_W-1:0]     A;
    logic [N_CODES-1:0] D;
    logic               busy;
    logic               done;
    logic               pass;
    logic [CNT_W-1:0]   err_cnt;
    logic [N_CODES-1:0] sa0_mask;
    logic [N_CODES-1:0] sa1_mask;
`ifdef FIRST_FAULT_CAPTURE_EN
    logic [A_W-1:0]     first_addr;
    logic               first_vld;

    modport master (
        output start, valid, A, D,
        input  busy, done, pass, err_cnt, sa0_mask, sa1_mask, first_addr, first_vld
    );
    modport slave (
        input  start, valid, A, D,
        output busy, done, pass, err_cnt, sa0_mask, sa1_mask, first_addr, first_vld
    );
`else
    modport master (
        output start, valid, A, D,
        input  busy, done, pass, err_cnt, sa0_mask, sa1_mask
    );
    modport slave (
        input  start, valid, A, D,
        output busy, done, pass, err_cnt, sa0_mask, sa1_mask
    );
`endif
endinterface

// File: rtl/dec_fault_monitor.sv
// Session-based checker for a 4-to-16 decoder: compares D against one-hot(A) over 16 samples.
// Optional FIRST_FAULT_CAPTURE_EN records the address of the first mismatching sample.
module dec_fault_monitor #(
    parameter int unsigned N_CODES = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dec_fault_monitor_if.slave   bus
);
    localparam int unsigned A_W = $clog2(N_CODES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [A_W-1:0]     sample_cnt;
    logic               busy_q;
    logic               done_q;
    logic               pass_q;
    logic [CNT_W-1:0]   err_cnt_q;
    logic [N_CODES-1:0] sa0_q;
    logic [N_CODES-1:0] sa1_q;
`ifdef FIRST_FAULT_CAPTURE_EN
    logic [A_W-1:0]     first_addr_q;
    logic               first_vld_q;
`endif

    logic [N_CODES-1:0] expect_vec;
    logic               mismatch;
    logic [CNT_W-1:0]   err_cnt_nxt;

    // Expected one-hot vector and the error count including the current sample.
    always_comb begin
        expect_vec  = N_CODES'(1) << bus.A;
        mismatch    = (bus.D != expect_vec);
        err_cnt_nxt = err_cnt_q;
        if (mismatch && (err_cnt_q != CNT_W'(N_CODES))) begin
            err_cnt_nxt = err_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            sample_cnt   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_cnt_q    <= '0;
            sa0_q        <= '0;
            sa1_q        <= '0;
`ifdef FIRST_FAULT_CAPTURE_EN
            first_addr_q <= '0;
            first_vld_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    // A valid coinciding with start is deliberately dropped.
                    if (bus.start) begin
                        state       <= RUN;
                        busy_q      <= 1'b1;
                        sample_cnt  <= '0;
                        pass_q      <= 1'b0;
                        err_cnt_q   <= '0;
                        sa0_q       <= '0;
                        sa1_q       <= '0;
`ifdef FIRST_FAULT_CAPTURE_EN
                        first_vld_q <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    if (bus.valid) begin
                        sa0_q     <= sa0_q | (expect_vec & ~bus.D);
                        sa1_q     <= sa1_q | (bus.D & ~expect_vec);
                        err_cnt_q <= err_cnt_nxt;
`ifdef FIRST_FAULT_CAPTURE_EN
                        if (mismatch && !first_vld_q) begin
                            first_addr_q <= bus.A;
                            first_vld_q  <= 1'b1;
                        end
`endif
                        if (sample_cnt == A_W'(N_CODES - 1)) begin
                            state  <= DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            pass_q <= (err_cnt_nxt == '0);
                        end else begin
                            sample_cnt <= sample_cnt + A_W'(1);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.pass     = pass_q;
    assign bus.err_cnt  = err_cnt_q;
    assign bus.sa0_mask = sa0_q;
    assign bus.sa1_mask = sa1_q;
`ifdef FIRST_FAULT_CAPTURE_EN
    assign bus.first_addr = first_addr_q;
    assign bus.first_vld  = first_vld_q;
`endif

endmodule

// File: tb/tb_dec_fault_monitor.sv
// Scoreboard bench for dec_fault_monitor: stimulus queues hand-computed session results,
// a negedge monitor pops and compares them whenever done is seen.
module tb_dec_fault_monitor;
    localparam int unsigned N_CODES = 16;
    localparam int unsigned CNT_W   = 5;

    typedef struct {
        logic        pass;
        logic [4:0]  err;
        logic [15:0] sa0;
        logic [15:0] sa1;
        logic [3:0]  fa;
        logic        fv;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dec_fault_monitor_if #(.N_CODES(N_CODES), .CNT_W(CNT_W)) bus ();
    dec_fault_monitor #(.N_CODES(N_CODES), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int    n_tests = 0;
    int    n_fail  = 0;
    int    n_done  = 0;
    exp_t  sb[$];
    exp_t  mon_e;
    logic [15:0] dv [16];
    int          gaps [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic p, input logic [4:0] e, input logic [15:0] s0,
                                input logic [15:0] s1, input logic [3:0] fa, input logic fv);
        exp_t r;
        r.pass = p; r.err = e; r.sa0 = s0; r.sa1 = s1; r.fa = fa; r.fv = fv;
        return r;
    endfunction

    // Result monitor: one expected entry per done pulse.
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            n_done++;
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected_done: got done with empty queue, want no done");
            end else begin
                mon_e = sb.pop_front();
                check("sb_pass",     32'(bus.pass),     32'(mon_e.pass));
                check("sb_err_cnt",  32'(bus.err_cnt),  32'(mon_e.err));
                check("sb_sa0_mask", 32'(bus.sa0_mask), 32'(mon_e.sa0));
                check("sb_sa1_mask", 32'(bus.sa1_mask), 32'(mon_e.sa1));
                check("sb_busy_lo",  32'(bus.busy),     32'(0));
`ifdef FIRST_FAULT_CAPTURE_EN
                check("sb_first_vld", 32'(bus.first_vld), 32'(mon_e.fv));
                if (mon_e.fv) check("sb_first_addr", 32'(bus.first_addr), 32'(mon_e.fa));
`endif
            end
        end
    end

    task automatic do_start();
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic do_sample(input logic [3:0] a, input logic [15:0] d);
        bus.valid = 1'b1;
        bus.A     = a;
        bus.D     = d;
        @(posedge clk); #1;
        bus.valid = 1'b0;
    endtask

    task automatic fill_good();
        for (int i = 0; i < 16; i++) begin
            dv[i]   = 16'h0001 << i;
            gaps[i] = 0;
        end
    endtask

    // Run 16 samples with optional idle gaps; busy must stay high, done low, through gaps.
    task automatic sweep(input string name);
        for (int i = 0; i < 16; i++) begin
            for (int g = 0; g < gaps[i]; g++) begin
                @(posedge clk); #1;
                check({name, "_gap_busy_done"}, 32'({bus.busy, bus.done}), 32'(2'b10));
            end
            if (i == 15) check({name, "_no_done_before_16"}, 32'(bus.done), 32'(0));
            do_sample(4'(i), dv[i]);
        end
        check({name, "_done_after_16"}, 32'(bus.done), 32'(1));
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_busy"},    32'(bus.busy),     32'(0));
        check({name, "_done"},    32'(bus.done),     32'(0));
        check({name, "_pass"},    32'(bus.pass),     32'(0));
        check({name, "_err_cnt"}, 32'(bus.err_cnt),  32'(0));
        check({name, "_sa0"},     32'(bus.sa0_mask), 32'(0));
        check({name, "_sa1"},     32'(bus.sa1_mask), 32'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want normal completion");
        $fatal(1);
    end

    initial begin
        bus.start = 1'b0;
        bus.valid = 1'b0;
        bus.A     = '0;
        bus.D     = '0;
        #12;
        check_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Fault-free; valid with start is dropped, valid during DONE is ignored.
        sb.push_back(mk(1'b1, 5'd0, 16'h0000, 16'h0000, 4'd0, 1'b0));
        bus.valid = 1'b1; bus.A = 4'd0; bus.D = 16'h0000;
        do_start();
        check("clean_busy_after_start", 32'(bus.busy), 32'(1));
        check("clean_start_valid_ignored", 32'(bus.err_cnt), 32'(0));
        fill_good();
        sweep("clean");
        bus.valid = 1'b1; bus.A = 4'd3; bus.D = 16'hFFFF;
        @(posedge clk); #1;
        bus.valid = 1'b0;
        check("clean_done_one_cycle", 32'(bus.done), 32'(0));
        check("clean_done_valid_ignored", 32'(bus.sa1_mask), 32'(0));
        check("clean_pass_held", 32'(bus.pass), 32'(1));

        // Stuck-at-0 on line 5; check single-cycle latency at the faulty sample.
        sb.push_back(mk(1'b0, 5'd1, 16'h0020, 16'h0000, 4'd5, 1'b1));
        do_start();
        check("sa0_cleared_pass", 32'(bus.pass), 32'(0));
        for (int i = 0; i < 16; i++) begin
            do_sample(4'(i), (16'h0001 << i) & 16'hFFDF);
            if (i == 4) check("sa0_before_fault", 32'(bus.err_cnt), 32'(0));
            if (i == 5) begin
                check("sa0_latency_err", 32'(bus.err_cnt), 32'(1));
                check("sa0_latency_mask", 32'(bus.sa0_mask), 32'h0020);
            end
        end
        check("sa0_done", 32'(bus.done), 32'(1));
        @(posedge clk); #1;
        // Valid in IDLE must not disturb held results.
        for (int i = 0; i < 3; i++) do_sample(4'(i), 16'h0000);
        check("idle_hold_err", 32'(bus.err_cnt), 32'(1));
        check("idle_hold_sa0", 32'(bus.sa0_mask), 32'h0020);
        check("idle_hold_pass", 32'(bus.pass), 32'(0));
        check("idle_not_busy", 32'(bus.busy), 32'(0));

        // W stuck-at-0 in low half: codes 1,3,5,7 decode as 0,2,4,6.
        sb.push_back(mk(1'b0, 5'd4, 16'h00AA, 16'h0055, 4'd1, 1'b1));
        do_start();
        fill_good();
        dv[1] = 16'h0001; dv[3] = 16'h0004; dv[5] = 16'h0010; dv[7] = 16'h0040;
        sweep("wsa0");
        @(posedge clk); #1;

        // Gapped valid: 16 samples across 40 cycles, one fault (A=9 reads 0).
        sb.push_back(mk(1'b0, 5'd1, 16'h0200, 16'h0000, 4'd9, 1'b1));
        do_start();
        fill_good();
        gaps = '{0, 3, 1, 0, 2, 4, 0, 1, 2, 0, 3, 1, 2, 0, 3, 2};
        dv[9] = 16'h0000;
        sweep("gap");
        @(posedge clk); #1;

        // Reset mid-RUN after 7 samples (one faulty), then a fresh full session.
        do_start();
        for (int i = 0; i < 7; i++) do_sample(4'(i), (i == 3) ? 16'h0000 : (16'h0001 << i));
        check("prereset_err", 32'(bus.err_cnt), 32'(1));
        #2 rst_n = 1'b0;
        #1 check_all_zero("midrun_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) do_sample(4'(i), 16'h8000);
        check("post_reset_needs_start", 32'(bus.busy), 32'(0));
        check("post_reset_no_err", 32'(bus.err_cnt), 32'(0));
        sb.push_back(mk(1'b1, 5'd0, 16'h0000, 16'h0000, 4'd0, 1'b0));
        do_start();
        fill_good();
        sweep("rerun");
        @(posedge clk); #1;

        // start during RUN at sample 9 is ignored; earlier fault at A=2 survives.
        sb.push_back(mk(1'b0, 5'd2, 16'h0004, 16'h0001, 4'd2, 1'b1));
        do_start();
        for (int i = 0; i < 16; i++) begin
            logic [15:0] d;
            d = 16'h0001 << i;
            if (i == 2)  d = 16'h0000;
            if (i == 12) d = 16'h1001;
            bus.start = (i == 8);
            do_sample(4'(i), d);
            bus.start = 1'b0;
            if (i == 8) begin
                check("midstart_err_kept", 32'(bus.err_cnt), 32'(1));
                check("midstart_sa0_kept", 32'(bus.sa0_mask), 32'h0004);
                check("midstart_busy", 32'(bus.busy), 32'(1));
            end
        end
        check("midstart_done_after_16", 32'(bus.done), 32'(1));
        @(posedge clk); #1;
        @(posedge clk); #1;

        check("done_count", 32'(n_done), 32'(6));
        check("sb_empty", 32'(sb.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
